// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the mips_32 register file: per-source FIFOs, round-robin onto the single write port, RAW scoreboard.
// Optional feature macro: REG_ZERO_PROTECT_EN (requests to register 0 never assert wren).

module reg_wb_fifo #(
   parameter int AW    = 4,
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                aclr_n,
   input  logic                i_valid,
   input  logic [AW-1:0]       i_addr,
   input  logic [DW-1:0]       i_data,
   input  logic                i_pop,
   output logic                o_ready,
   output logic                o_head_vld,
   output logic [AW-1:0]       o_head_addr,
   output logic [DW-1:0]       o_head_data,
   output logic [(1<<AW)-1:0]  o_mask
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] r_addr [DEPTH];
   logic [DW-1:0] r_data [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_pushed;
   logic          w_push;
   logic [CW-1:0] w_vis_cnt;

   assign o_ready     = (r_cnt != CW'(DEPTH));
   assign w_push      = i_valid & o_ready;
   // the newest entry stays hidden from the arbiter for one cycle after its push
   assign w_vis_cnt   = r_cnt - {{PW{1'b0}}, r_pushed};
   assign o_head_vld  = (w_vis_cnt != '0);
   assign o_head_addr = r_addr[r_rd_ptr];
   assign o_head_data = r_data[r_rd_ptr];

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_cnt    <= '0;
         r_pushed <= 1'b0;
      end else begin
         r_pushed <= w_push;
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         r_cnt <= r_cnt + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, i_pop};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_addr[r_wr_ptr] <= i_addr;
         r_data[r_wr_ptr] <= i_data;
      end
   end

   always_comb begin
      o_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < r_cnt) o_mask[r_addr[r_rd_ptr + PW'(i)]] = 1'b1;
      end
   end
endmodule

module reg_wb_arbiter #(
   parameter int AW    = 4,
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic                clk,
   input  logic                aclr_n,
   input  logic                a_valid,
   output logic                a_ready,
   input  logic [AW-1:0]       a_addr,
   input  logic [DW-1:0]       a_data,
   input  logic                b_valid,
   output logic                b_ready,
   input  logic [AW-1:0]       b_addr,
   input  logic [DW-1:0]       b_data,
   output logic                wren,
   output logic [AW-1:0]       wraddress,
   output logic [DW-1:0]       data,
   input  logic [AW-1:0]       rdaddress_1,
   input  logic [AW-1:0]       rdaddress_2,
   output logic                hazard_1,
   output logic                hazard_2,
   output logic [(1<<AW)-1:0]  pending_mask
);
   localparam int NR = 1 << AW;

   logic          w_a_vld, w_b_vld;
   logic [AW-1:0] w_a_addr, w_b_addr;
   logic [DW-1:0] w_a_data, w_b_data;
   logic [NR-1:0] w_a_mask, w_b_mask, w_wr_mask, w_pending;
   logic          w_grant_a, w_grant_b, w_wr_en;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_data;
   logic          r_ptr_b;
   logic          r_wren;
   logic [AW-1:0] r_wraddress;
   logic [DW-1:0] r_data;

   reg_wb_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fifo_a (
      .clk(clk), .aclr_n(aclr_n),
      .i_valid(a_valid), .i_addr(a_addr), .i_data(a_data), .i_pop(w_grant_a),
      .o_ready(a_ready), .o_head_vld(w_a_vld), .o_head_addr(w_a_addr),
      .o_head_data(w_a_data), .o_mask(w_a_mask)
   );

   reg_wb_fifo #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) u_fifo_b (
      .clk(clk), .aclr_n(aclr_n),
      .i_valid(b_valid), .i_addr(b_addr), .i_data(b_data), .i_pop(w_grant_b),
      .o_ready(b_ready), .o_head_vld(w_b_vld), .o_head_addr(w_b_addr),
      .o_head_data(w_b_data), .o_mask(w_b_mask)
   );

   always_comb begin
      w_grant_a  = w_a_vld & (~w_b_vld | ~r_ptr_b);
      w_grant_b  = w_b_vld & (~w_a_vld |  r_ptr_b);
      w_sel_addr = w_grant_a ? w_a_addr : w_b_addr;
      w_sel_data = w_grant_a ? w_a_data : w_b_data;
   end

`ifdef REG_ZERO_PROTECT_EN
   // register 0 writes still burn their slot but never reach the RAM
   assign w_wr_en = (w_sel_addr != '0);
`else
   assign w_wr_en = 1'b1;
`endif

   always_ff @(posedge clk or negedge aclr_n) begin
      if (!aclr_n) begin
         r_ptr_b     <= 1'b0;
         r_wren      <= 1'b0;
         r_wraddress <= '0;
         r_data      <= '0;
      end else if (w_grant_a | w_grant_b) begin
         r_wren      <= w_wr_en;
         r_wraddress <= w_sel_addr;
         r_data      <= w_sel_data;
         r_ptr_b     <= w_grant_a;
      end else begin
         r_wren      <= 1'b0;
      end
   end

   always_comb begin
      w_wr_mask = '0;
      w_wr_mask[r_wraddress] = r_wren;
   end

   assign w_pending = w_a_mask | w_b_mask | w_wr_mask;

`ifdef REG_ZERO_PROTECT_EN
   assign pending_mask = w_pending & ~NR'(1);
`else
   assign pending_mask = w_pending;
`endif

   assign wren      = r_wren;
   assign wraddress = r_wraddress;
   assign data      = r_data;
   assign hazard_1  = pending_mask[rdaddress_1];
   assign hazard_2  = pending_mask[rdaddress_2];
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, hand sequences, and a randomized run against a queue-based model.
module tb_reg_wb_arbiter;
   localparam int AW = 4, DW = 32, DEPTH = 2, NR = 16;

   logic clk = 1'b0, aclr_n = 1'b0;
   logic a_valid = 1'b0, b_valid = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0, rdaddress_1 = '0, rdaddress_2 = '0;
   logic [DW-1:0] a_data = '0, b_data = '0;
   logic a_ready, b_ready, wren, hazard_1, hazard_2;
   logic [AW-1:0] wraddress;
   logic [DW-1:0] data;
   logic [NR-1:0] pending_mask;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .aclr_n(aclr_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
      .wren(wren), .wraddress(wraddress), .data(data),
      .rdaddress_1(rdaddress_1), .rdaddress_2(rdaddress_2),
      .hazard_1(hazard_1), .hazard_2(hazard_2), .pending_mask(pending_mask)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic av; logic [AW-1:0] aa; logic [DW-1:0] ad;
      logic bv; logic [AW-1:0] ba; logic [DW-1:0] bd;
      logic [AW-1:0] r1; logic [AW-1:0] r2;
      logic ew; logic [AW-1:0] ewa; logic [DW-1:0] ed; logic eh1; logic eh2;
   } vec_t;
   vec_t vt [13];

   typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; int t; } ent_t;

   // reference model: queues of accepted writes, each stamped with its push edge
   ent_t qa[$], qb[$];
   int n_edge;
   bit pref_a, a_hold, b_hold;
   logic m_wren;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;

   function automatic bit wr_ok(input logic [AW-1:0] a);
`ifdef REG_ZERO_PROTECT_EN
      return a != '0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [NR-1:0] model_mask();
      logic [NR-1:0] m = '0;
      foreach (qa[i]) m[qa[i].addr] = 1'b1;
      foreach (qb[i]) m[qb[i].addr] = 1'b1;
      if (m_wren) m[m_wa] = 1'b1;
`ifdef REG_ZERO_PROTECT_EN
      m[0] = 1'b0;
`endif
      return m;
   endfunction

   task automatic model_edge();
      bit ra, rb, ea, eb;
      ent_t e;
      n_edge++;
      ra = qa.size() < DEPTH;
      rb = qb.size() < DEPTH;
      ea = (qa.size() > 0) && (qa[0].t + 2 <= n_edge);
      eb = (qb.size() > 0) && (qb[0].t + 2 <= n_edge);
      if (ea && (!eb || pref_a)) begin
         e = qa.pop_front(); m_wren = wr_ok(e.addr); m_wa = e.addr; m_wd = e.data; pref_a = 1'b0;
      end else if (eb) begin
         e = qb.pop_front(); m_wren = wr_ok(e.addr); m_wa = e.addr; m_wd = e.data; pref_a = 1'b1;
      end else begin
         m_wren = 1'b0;
      end
      a_hold = a_valid && !ra;
      b_hold = b_valid && !rb;
      if (a_valid && ra) qa.push_back('{a_addr, a_data, n_edge});
      if (b_valid && rb) qb.push_back('{b_addr, b_data, n_edge});
   endtask

   // stream runner state
   ent_t sa[$], sb[$];
   logic [AW-1:0] wlog[$];
   logic [DW-1:0] dlog[$];
   int first_w, last_w, b_rdy_at2, b_writes_at_b3;

   task automatic run_stream(input int max_cyc, output bit done);
      int nb_acc, last_act, nbw;
      nb_acc = 0; last_act = 0;
      first_w = -1; last_w = -1; b_rdy_at2 = -1; b_writes_at_b3 = -1;
      wlog.delete(); dlog.delete();
      done = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         if (wren) begin
            if (first_w < 0) first_w = c;
            last_w = c; last_act = c;
            wlog.push_back(wraddress); dlog.push_back(data);
         end
         if (c == 2) b_rdy_at2 = int'(b_ready);
         a_valid = sa.size() > 0;
         if (a_valid) begin a_addr = sa[0].addr; a_data = sa[0].data; end
         b_valid = sb.size() > 0;
         if (b_valid) begin b_addr = sb[0].addr; b_data = sb[0].data; end
         #1;
         if (a_valid && a_ready) begin void'(sa.pop_front()); last_act = c; end
         if (b_valid && b_ready) begin
            nb_acc++; last_act = c;
            if (nb_acc == 3) begin
               nbw = 0;
               foreach (wlog[i]) if (wlog[i] >= 4'd9) nbw++;
               b_writes_at_b3 = nbw;
            end
            void'(sb.pop_front());
         end
         if (sa.size() == 0 && sb.size() == 0 && c >= last_act + 6) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;
   endtask

   task automatic do_reset();
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      aclr_n = 1'b0;
      repeat (2) @(negedge clk);
      aclr_n = 1'b1;
   endtask

   int exp_ord [8];
   int ia, ib;
   bit done, saw, saw_w, saw_w0, saw_p0;
   logic [NR-1:0] mm;

   initial begin
      vt[0]  = '{1'b1, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 32'h0,  4'd5, 4'd8, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0};
      vt[1]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd5, 4'd8, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0};
      vt[2]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd5, 4'd8, 1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0};
      vt[3]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd5, 4'd8, 1'b0, 4'd5, 32'hDEADBEEF, 1'b0, 1'b0};
      vt[4]  = '{1'b1, 4'd7, 32'h77,       1'b0, 4'd0, 32'h0,  4'd7, 4'd8, 1'b0, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd7, 4'd8, 1'b0, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd7, 4'd8, 1'b1, 4'd7, 32'h77,       1'b1, 1'b0};
      vt[7]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd7, 4'd8, 1'b0, 4'd7, 32'h77,       1'b0, 1'b0};
      vt[8]  = '{1'b1, 4'd6, 32'h66,       1'b1, 4'd3, 32'h33, 4'd3, 4'd6, 1'b0, 4'd7, 32'h77,       1'b1, 1'b1};
      vt[9]  = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd3, 4'd6, 1'b0, 4'd7, 32'h77,       1'b1, 1'b1};
      vt[10] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd3, 4'd6, 1'b1, 4'd3, 32'h33,       1'b1, 1'b1};
      vt[11] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd3, 4'd6, 1'b1, 4'd6, 32'h66,       1'b0, 1'b1};
      vt[12] = '{1'b0, 4'd0, 32'h0,        1'b0, 4'd0, 32'h0,  4'd3, 4'd6, 1'b0, 4'd6, 32'h66,       1'b0, 1'b0};
      exp_ord = '{1, 9, 2, 10, 3, 11, 4, 12};

      // reset state and directed vector table
      do_reset();
      chk("rst_wren", 64'(wren), 64'd0);
      chk("rst_wraddress", 64'(wraddress), 64'd0);
      chk("rst_data", 64'(data), 64'd0);
      chk("rst_mask", 64'(pending_mask), 64'd0);
      chk("rst_a_ready", 64'(a_ready), 64'd1);
      chk("rst_b_ready", 64'(b_ready), 64'd1);
      for (int r = 0; r < 13; r++) begin
         a_valid = vt[r].av; a_addr = vt[r].aa; a_data = vt[r].ad;
         b_valid = vt[r].bv; b_addr = vt[r].ba; b_data = vt[r].bd;
         rdaddress_1 = vt[r].r1; rdaddress_2 = vt[r].r2;
         @(negedge clk);
         chk($sformatf("vec%0d_wren", r),      64'(wren),      64'(vt[r].ew));
         chk($sformatf("vec%0d_wraddress", r), 64'(wraddress), 64'(vt[r].ewa));
         chk($sformatf("vec%0d_data", r),      64'(data),      64'(vt[r].ed));
         chk($sformatf("vec%0d_hazard_1", r),  64'(hazard_1),  64'(vt[r].eh1));
         chk($sformatf("vec%0d_hazard_2", r),  64'(hazard_2),  64'(vt[r].eh2));
      end

      // interleave: A 1..4 and B 9..12 offered every cycle
      do_reset();
      sa.delete(); sb.delete();
      for (int i = 0; i < 4; i++) begin
         sa.push_back('{AW'(1 + i), 32'hA000_0000 + 32'(1 + i), 0});
         sb.push_back('{AW'(9 + i), 32'hB000_0000 + 32'(9 + i), 0});
      end
      run_stream(60, done);
      chk("il_done", 64'(done), 64'd1);
      chk("il_count", 64'(wlog.size()), 64'd8);
      for (int i = 0; i < 8 && i < wlog.size(); i++) begin
         chk($sformatf("il_addr%0d", i), 64'(wlog[i]), 64'(exp_ord[i]));
         chk($sformatf("il_data%0d", i), 64'(dlog[i]),
             64'((exp_ord[i] >= 9 ? 32'hB000_0000 : 32'hA000_0000) + 32'(exp_ord[i])));
      end
      chk("il_contiguous", 64'(last_w - first_w + 1), 64'd8);

      // backpressure: A floods, B offers three back-to-back
      do_reset();
      sa.delete(); sb.delete();
      for (int i = 0; i < 6; i++) sa.push_back('{AW'(1 + i), 32'h100 + 32'(i), 0});
      for (int i = 0; i < 3; i++) sb.push_back('{AW'(9 + i), 32'h200 + 32'(i), 0});
      run_stream(80, done);
      chk("bp_done", 64'(done), 64'd1);
      chk("bp_b_ready_full", 64'(b_rdy_at2), 64'd0);
      chk("bp_b3_after_pop", 64'(b_writes_at_b3 >= 1), 64'd1);
      ia = 0; ib = 0;
      foreach (wlog[i]) begin
         if (wlog[i] >= 4'd9) begin
            chk($sformatf("bp_b_order%0d", ib), 64'(wlog[i]), 64'(9 + ib)); ib++;
         end else begin
            chk($sformatf("bp_a_order%0d", ia), 64'(wlog[i]), 64'(1 + ia)); ia++;
         end
      end
      chk("bp_a_total", 64'(ia), 64'd6);
      chk("bp_b_total", 64'(ib), 64'd3);

      // asynchronous reset with three entries queued and a write on the port
      do_reset();
      a_valid = 1'b1; a_addr = 4'd1; a_data = 32'h11; b_valid = 1'b1; b_addr = 4'd9; b_data = 32'h99;
      @(negedge clk);
      a_addr = 4'd2; a_data = 32'h22; b_addr = 4'd10; b_data = 32'hAA;
      @(negedge clk);
      a_valid = 1'b0; b_valid = 1'b0;
      @(negedge clk);
      chk("ar_pre_wren", 64'(wren), 64'd1);
      chk("ar_pre_wraddress", 64'(wraddress), 64'd1);
      #2 aclr_n = 1'b0;
      #1;
      chk("ar_wren", 64'(wren), 64'd0);
      chk("ar_wraddress", 64'(wraddress), 64'd0);
      chk("ar_data", 64'(data), 64'd0);
      chk("ar_mask", 64'(pending_mask), 64'd0);
      chk("ar_a_ready", 64'(a_ready), 64'd1);
      chk("ar_b_ready", 64'(b_ready), 64'd1);
      @(negedge clk);
      aclr_n = 1'b1;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (wren || pending_mask != '0) saw = 1'b1;
      end
      chk("ar_no_writes", 64'(saw), 64'd0);

      // register 0 write
      do_reset();
      a_valid = 1'b1; a_addr = 4'd0; a_data = 32'h1234;
      @(negedge clk);
      a_valid = 1'b0;
      saw_w = 1'b0; saw_w0 = 1'b0; saw_p0 = 1'b0;
      repeat (6) begin
         if (wren) saw_w = 1'b1;
         if (wren && wraddress == 4'd0 && data == 32'h1234) saw_w0 = 1'b1;
         if (pending_mask[0]) saw_p0 = 1'b1;
         @(negedge clk);
      end
`ifdef REG_ZERO_PROTECT_EN
      chk("zero_no_wren", 64'(saw_w), 64'd0);
      chk("zero_no_pending", 64'(saw_p0), 64'd0);
`else
      chk("zero_written", 64'(saw_w0), 64'd1);
      chk("zero_pending_seen", 64'(saw_p0), 64'd1);
`endif

      // randomized traffic against the model
      do_reset();
      qa.delete(); qb.delete();
      n_edge = 0; pref_a = 1'b1; a_hold = 1'b0; b_hold = 1'b0;
      m_wren = 1'b0; m_wa = '0; m_wd = '0;
      for (int c = 0; c < 3000; c++) begin
         if (!a_hold) begin
            a_valid = ($urandom_range(0, 3) != 0); a_addr = AW'($urandom); a_data = $urandom;
         end
         if (!b_hold) begin
            b_valid = ($urandom_range(0, 2) != 0); b_addr = AW'($urandom); b_data = $urandom;
         end
         rdaddress_1 = AW'($urandom);
         rdaddress_2 = AW'($urandom);
         #1;
         mm = model_mask();
         chk("rnd_a_ready", 64'(a_ready), 64'(qa.size() < DEPTH));
         chk("rnd_b_ready", 64'(b_ready), 64'(qb.size() < DEPTH));
         chk("rnd_wren", 64'(wren), 64'(m_wren));
         chk("rnd_wraddress", 64'(wraddress), 64'(m_wa));
         chk("rnd_data", 64'(data), 64'(m_wd));
         chk("rnd_mask", 64'(pending_mask), 64'(mm));
         chk("rnd_hazard_1", 64'(hazard_1), 64'(mm[rdaddress_1]));
         chk("rnd_hazard_2", 64'(hazard_2), 64'(mm[rdaddress_2]));
         model_edge();
         @(negedge clk);
      end
      a_valid = 1'b0; b_valid = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
